// File: rtl/biriscv_branch_predictor.sv
// Fetch-side branch predictor: direct-mapped BTB with 2-bit counters
// plus a return address stack, updated from execute-stage resolutions.
//
// Ports:
//   clk_i, rst_i              clock, async active-high reset
//   pc_f_i                    fetch PC being looked up
//   branch_request_i          resolved branch valid this cycle
//   branch_is_taken_i         resolved branch was taken
//   branch_is_not_taken_i     conditional branch was not taken
//   branch_source_i           PC of the resolved branch
//   branch_pc_i               resolved target (valid when taken)
//   branch_is_call_i/ret/jmp  branch type flags
//   next_pc_f_o               predicted next fetch PC
//   next_taken_f_o            prediction is a taken redirect
module biriscv_branch_predictor #(
    parameter int NUM_BTB_ENTRIES   = 32,
    parameter int NUM_BTB_ENTRIES_W = 5,
    parameter int NUM_RAS_ENTRIES   = 8,
    parameter int NUM_RAS_ENTRIES_W = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] pc_f_i,
    input  logic        branch_request_i,
    input  logic        branch_is_taken_i,
    input  logic        branch_is_not_taken_i,
    input  logic [31:0] branch_source_i,
    input  logic [31:0] branch_pc_i,
    input  logic        branch_is_call_i,
    input  logic        branch_is_ret_i,
    input  logic        branch_is_jmp_i,
    output logic [31:0] next_pc_f_o,
    output logic        next_taken_f_o
);

    localparam int BW = NUM_BTB_ENTRIES_W;
    localparam int RW = NUM_RAS_ENTRIES_W;
    localparam logic [RW:0] RAS_FULL = RW'(NUM_RAS_ENTRIES - 1) + 1'b1;

    logic [NUM_BTB_ENTRIES-1:0] btb_valid_q;
    logic [1:0]  btb_cnt_q    [NUM_BTB_ENTRIES];
    logic [29:0] btb_tag_q    [NUM_BTB_ENTRIES];
    logic [31:0] btb_target_q [NUM_BTB_ENTRIES];
    logic        btb_call_q   [NUM_BTB_ENTRIES];
    logic        btb_ret_q    [NUM_BTB_ENTRIES];
    logic        btb_jmp_q    [NUM_BTB_ENTRIES];

    logic [31:0] ras_q [NUM_RAS_ENTRIES];
    logic [RW-1:0] ras_ptr_q;
    logic [RW:0]   ras_cnt_q;

    // ---------------- update side ----------------
    logic [BW-1:0] upd_idx;
    logic          upd_hit;
    logic          upd_taken;
    logic          upd_nt;
    logic          upd_uncond;
    logic [1:0]    upd_cnt;

    assign upd_idx    = branch_source_i[BW+1:2];
    assign upd_hit    = btb_valid_q[upd_idx] &&
                        (btb_tag_q[upd_idx] == branch_source_i[31:2]);
    // Taken wins when both taken and not-taken are flagged
    assign upd_taken  = branch_is_taken_i;
    assign upd_nt     = branch_is_not_taken_i && !branch_is_taken_i;
    assign upd_uncond = branch_is_call_i | branch_is_ret_i | branch_is_jmp_i;

    always_comb begin
        upd_cnt = btb_cnt_q[upd_idx];
        if (upd_uncond)
            upd_cnt = 2'b11;
        else if (upd_taken && !upd_hit)
            upd_cnt = 2'b10;
        else if (upd_taken && upd_cnt != 2'b11)
            upd_cnt = upd_cnt + 2'b01;
        else if (upd_nt && upd_cnt != 2'b00)
            upd_cnt = upd_cnt - 2'b01;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            btb_valid_q <= '0;
            for (int i = 0; i < NUM_BTB_ENTRIES; i++)
                btb_cnt_q[i] <= 2'b00;
        end else if (branch_request_i && (upd_taken || (upd_nt && upd_hit))) begin
            btb_valid_q[upd_idx] <= 1'b1;
            btb_cnt_q[upd_idx]   <= upd_cnt;
        end
    end

    // Tags, targets and flags carry no reset; valid gates their use
    always_ff @(posedge clk_i) begin
        if (branch_request_i && (upd_taken || upd_hit)) begin
            btb_call_q[upd_idx] <= branch_is_call_i;
            btb_ret_q[upd_idx]  <= branch_is_ret_i;
            btb_jmp_q[upd_idx]  <= branch_is_jmp_i;
            if (upd_taken) begin
                btb_tag_q[upd_idx]    <= branch_source_i[31:2];
                btb_target_q[upd_idx] <= branch_pc_i;
            end
        end
    end

    // ---------------- return address stack ----------------
    logic ras_push;
    logic ras_pop;

    assign ras_push = branch_request_i && branch_is_call_i;
    assign ras_pop  = branch_request_i && branch_is_ret_i &&
                      !branch_is_call_i && (ras_cnt_q != '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ras_ptr_q <= '0;
            ras_cnt_q <= '0;
        end else if (ras_push) begin
            ras_ptr_q <= ras_ptr_q + 1'b1;
            if (ras_cnt_q != RAS_FULL)
                ras_cnt_q <= ras_cnt_q + 1'b1;
        end else if (ras_pop) begin
            ras_ptr_q <= ras_ptr_q - 1'b1;
            ras_cnt_q <= ras_cnt_q - 1'b1;
        end
    end

    // Overflow simply overwrites the oldest slot as ptr wraps
    always_ff @(posedge clk_i) begin
        if (ras_push)
            ras_q[ras_ptr_q] <= branch_source_i + 32'd4;
    end

    // ---------------- lookup side ----------------
    logic [BW-1:0] lk_idx;
    logic          lk_hit;
    logic [31:0]   lk_seq;
    logic [31:0]   ras_top;
    logic [RW-1:0] ras_top_idx;

    assign lk_idx      = pc_f_i[BW+1:2];
    assign lk_hit      = btb_valid_q[lk_idx] &&
                         (btb_tag_q[lk_idx] == pc_f_i[31:2]);
    assign lk_seq      = pc_f_i + 32'd4;
    assign ras_top_idx = ras_ptr_q - 1'b1;
    assign ras_top     = ras_q[ras_top_idx];

    always_comb begin
        next_pc_f_o    = lk_seq;
        next_taken_f_o = 1'b0;
        if (lk_hit) begin
            if (btb_ret_q[lk_idx]) begin
                next_taken_f_o = 1'b1;
                next_pc_f_o    = (ras_cnt_q != '0) ? ras_top
                                                   : btb_target_q[lk_idx];
            end else if (btb_call_q[lk_idx] || btb_jmp_q[lk_idx]) begin
                next_taken_f_o = 1'b1;
                next_pc_f_o    = btb_target_q[lk_idx];
            end else if (btb_cnt_q[lk_idx][1]) begin
                next_taken_f_o = 1'b1;
                next_pc_f_o    = btb_target_q[lk_idx];
            end
        end
    end

endmodule

// File: tb/tb_biriscv_branch_predictor.sv
// Directed self-checking bench for biriscv_branch_predictor.
module tb_biriscv_branch_predictor;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [31:0] pc_f_i = '0;
    logic        branch_request_i = 1'b0;
    logic        branch_is_taken_i = 1'b0;
    logic        branch_is_not_taken_i = 1'b0;
    logic [31:0] branch_source_i = '0;
    logic [31:0] branch_pc_i = '0;
    logic        branch_is_call_i = 1'b0;
    logic        branch_is_ret_i = 1'b0;
    logic        branch_is_jmp_i = 1'b0;
    logic [31:0] next_pc_f_o;
    logic        next_taken_f_o;

    int n_pass = 0;
    int n_total = 0;

    biriscv_branch_predictor dut (
        .clk_i                 (clk_i),
        .rst_i                 (rst_i),
        .pc_f_i                (pc_f_i),
        .branch_request_i      (branch_request_i),
        .branch_is_taken_i     (branch_is_taken_i),
        .branch_is_not_taken_i (branch_is_not_taken_i),
        .branch_source_i       (branch_source_i),
        .branch_pc_i           (branch_pc_i),
        .branch_is_call_i      (branch_is_call_i),
        .branch_is_ret_i       (branch_is_ret_i),
        .branch_is_jmp_i       (branch_is_jmp_i),
        .next_pc_f_o           (next_pc_f_o),
        .next_taken_f_o        (next_taken_f_o)
    );

    always #5 clk_i = ~clk_i;

    // Drive one resolution for a single cycle; returns #1 after the edge
    task automatic resolve(input logic [31:0] src, input logic [31:0] tgt,
                           input logic tk, input logic nt,
                           input logic c, input logic r, input logic j);
        branch_request_i      = 1'b1;
        branch_source_i       = src;
        branch_pc_i           = tgt;
        branch_is_taken_i     = tk;
        branch_is_not_taken_i = nt;
        branch_is_call_i      = c;
        branch_is_ret_i       = r;
        branch_is_jmp_i       = j;
        @(posedge clk_i);
        #1;
        branch_request_i      = 1'b0;
        branch_is_taken_i     = 1'b0;
        branch_is_not_taken_i = 1'b0;
        branch_is_call_i      = 1'b0;
        branch_is_ret_i       = 1'b0;
        branch_is_jmp_i       = 1'b0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        pc_f_i = 32'h8000_0100;
        #1;
        n_total++;
        if ({next_taken_f_o, next_pc_f_o} !== {1'b0, 32'h8000_0104}) begin
            $display("FAIL reset_lookup got %h/%b want 80000104/0",
                     next_pc_f_o, next_taken_f_o);
        end else n_pass++;
        pc_f_i = 32'hFFFF_FFFC;
        #1;
        n_total++;
        if ({next_taken_f_o, next_pc_f_o} !== {1'b0, 32'h0000_0000}) begin
            $display("FAIL pc_wrap got %h/%b want 00000000/0",
                     next_pc_f_o, next_taken_f_o);
        end else n_pass++;
    endtask

    task automatic test_counter();
        logic [32:0] exp [9];
        exp[0] = {1'b1, 32'h8000_0040};
        exp[1] = {1'b0, 32'h8000_0104};
        exp[2] = {1'b0, 32'h8000_0104};
        exp[3] = {1'b0, 32'h8000_0104};
        exp[4] = {1'b0, 32'h8000_0104};
        exp[5] = {1'b1, 32'h8000_0040};
        exp[6] = {1'b1, 32'h8000_0040};
        exp[7] = {1'b1, 32'h8000_0040};
        exp[8] = {1'b1, 32'h8000_0040};
        do_reset();
        pc_f_i = 32'h8000_0100;
        // cnt: 2,1,0,0,1,2,3,3, then nt -> 2
        resolve(32'h8000_0100, 32'h8000_0040, 1, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) begin
            if (i > 0) begin
                if (i <= 3 || i == 8)
                    resolve(32'h8000_0100, 32'h0, 0, 1, 0, 0, 0);
                else
                    resolve(32'h8000_0100, 32'h8000_0040, 1, 0, 0, 0, 0);
            end
            n_total++;
            if ({next_taken_f_o, next_pc_f_o} !== exp[i]) begin
                $display("FAIL counter_step%0d got %h/%b want %h/%b", i,
                         next_pc_f_o, next_taken_f_o, exp[i][31:0], exp[i][32]);
            end else n_pass++;
        end
        // one more nt: cnt 1 -> not taken
        resolve(32'h8000_0100, 32'h0, 0, 1, 0, 0, 0);
        n_total++;
        if ({next_taken_f_o, next_pc_f_o} !== {1'b0, 32'h8000_0104}) begin
            $display("FAIL counter_down got %h/%b want 80000104/0",
                     next_pc_f_o, next_taken_f_o);
        end else n_pass++;
    endtask

    task automatic test_call_ret();
        do_reset();
        resolve(32'h8000_0200, 32'h8000_1000, 1, 0, 1, 0, 0);
        pc_f_i = 32'h8000_0200;
        #1;
        n_total++;
        if ({next_taken_f_o, next_pc_f_o} !== {1'b1, 32'h8000_1000}) begin
            $display("FAIL call_lookup got %h/%b want 80001000/1",
                     next_pc_f_o, next_taken_f_o);
        end else n_pass++;
        resolve(32'h8000_1010, 32'h8000_0204, 1, 0, 0, 1, 0);
        pc_f_i = 32'h8000_1010;
        #1;
        n_total++;
        if ({next_taken_f_o, next_pc_f_o} !== {1'b1, 32'h8000_0204}) begin
            $display("FAIL ret_empty_ras got %h/%b want 80000204/1",
                     next_pc_f_o, next_taken_f_o);
        end else n_pass++;
        resolve(32'h8000_0300, 32'h8000_1000, 1, 0, 1, 0, 0);
        #1;
        n_total++;
        if ({next_taken_f_o, next_pc_f_o} !== {1'b1, 32'h8000_0304}) begin
            $display("FAIL ret_from_ras got %h/%b want 80000304/1",
                     next_pc_f_o, next_taken_f_o);
        end else n_pass++;
    endtask

    task automatic test_ras_overflow();
        logic [31:0] want;
        do_reset();
        // ret entry allocated with an empty RAS: fallback target 0x80000AAC
        resolve(32'h8000_1010, 32'h8000_0AAC, 1, 0, 0, 1, 0);
        for (int k = 0; k < 9; k++)
            resolve(32'h8000_2000 + 32'h100 * k, 32'h8000_3000, 1, 0, 1, 0, 0);
        pc_f_i = 32'h8000_1010;
        for (int p = 0; p < 10; p++) begin
            if (p > 0)
                resolve(32'h8000_1010, 32'h8000_0AAC, 1, 0, 0, 1, 0);
            if (p < 8) want = 32'h8000_2004 + 32'h100 * (8 - p);
            else       want = 32'h8000_0AAC;
            #1;
            n_total++;
            if ({next_taken_f_o, next_pc_f_o} !== {1'b1, want}) begin
                $display("FAIL ras_pop%0d got %h/%b want %h/1", p,
                         next_pc_f_o, next_taken_f_o, want);
            end else n_pass++;
        end
    endtask

    task automatic test_alias();
        do_reset();
        resolve(32'h8000_0000, 32'h9000_0000, 1, 0, 0, 0, 0);
        resolve(32'h8000_0080, 32'hA000_0000, 1, 0, 0, 0, 0);
        pc_f_i = 32'h8000_0000;
        #1;
        n_total++;
        if ({next_taken_f_o, next_pc_f_o} !== {1'b0, 32'h8000_0004}) begin
            $display("FAIL alias_evict got %h/%b want 80000004/0",
                     next_pc_f_o, next_taken_f_o);
        end else n_pass++;
        resolve(32'h8000_0000, 32'h9000_0000, 0, 1, 0, 0, 0);
        resolve(32'h8000_0104, 32'h9000_0000, 0, 1, 0, 0, 0);
        pc_f_i = 32'h8000_0080;
        #1;
        n_total++;
        if ({next_taken_f_o, next_pc_f_o} !== {1'b1, 32'hA000_0000}) begin
            $display("FAIL alias_keep got %h/%b want a0000000/1",
                     next_pc_f_o, next_taken_f_o);
        end else n_pass++;
        pc_f_i = 32'h8000_0104;
        #1;
        n_total++;
        if ({next_taken_f_o, next_pc_f_o} !== {1'b0, 32'h8000_0108}) begin
            $display("FAIL nt_no_alloc got %h/%b want 80000108/0",
                     next_pc_f_o, next_taken_f_o);
        end else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        pc_f_i = 32'h8000_0100;
        branch_request_i  = 1'b1;
        branch_source_i   = 32'h8000_0100;
        branch_pc_i       = 32'h8000_0040;
        branch_is_taken_i = 1'b1;
        #2;
        n_total++;
        if ({next_taken_f_o, next_pc_f_o} !== {1'b0, 32'h8000_0104}) begin
            $display("FAIL same_cycle_old got %h/%b want 80000104/0",
                     next_pc_f_o, next_taken_f_o);
        end else n_pass++;
        @(posedge clk_i);
        #1;
        branch_request_i  = 1'b0;
        branch_is_taken_i = 1'b0;
        n_total++;
        if ({next_taken_f_o, next_pc_f_o} !== {1'b1, 32'h8000_0040}) begin
            $display("FAIL next_cycle_new got %h/%b want 80000040/1",
                     next_pc_f_o, next_taken_f_o);
        end else n_pass++;
        #2;
        rst_i = 1'b1;
        #1;
        n_total++;
        if ({next_taken_f_o, next_pc_f_o} !== {1'b0, 32'h8000_0104}) begin
            $display("FAIL async_reset got %h/%b want 80000104/0",
                     next_pc_f_o, next_taken_f_o);
        end else n_pass++;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_counter();
        test_call_ret();
        test_ras_overflow();
        test_alias();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
